// File: rtl/cpu_pkg.sv
// Shared decode constants and the control bundle
// carried from decode into execute.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LW    = 4'h1;
  localparam logic [3:0] OP_SW    = 4'h2;
  localparam logic [3:0] OP_BEQ   = 4'h3;
  localparam logic [3:0] OP_BNE   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_LOGI  = 4'h7;
  localparam logic [3:0] OP_NOP   = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_LOGI  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_unit_if.sv
// Opcode in, registered control word out.
// master = fetch/decode side, slave = control unit.
interface control_unit_if;

  logic [3:0] opcode;
  logic [1:0] alu_op;
  logic       jump;
  logic       beq;
  logic       bne;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_op;

  modport master (
    output opcode,
    input  alu_op,
    input  jump,
    input  beq,
    input  bne,
    input  mem_read,
    input  mem_write,
    input  alu_src,
    input  reg_dst,
    input  mem_to_reg,
    input  reg_write,
    input  illegal_op
  );

  modport slave (
    input  opcode,
    output alu_op,
    output jump,
    output beq,
    output bne,
    output mem_read,
    output mem_write,
    output alu_src,
    output reg_dst,
    output mem_to_reg,
    output reg_write,
    output illegal_op
  );

endinterface

// File: rtl/control_decode.sv
// Pure combinational opcode -> control bundle.
// Unlisted opcodes fall through to NOP + illegal.
module control_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  ctrl_t w_ctrl;
  logic  w_illegal;

  always_comb begin
    w_ctrl    = CTRL_NOP;
    w_illegal = 1'b0;
    unique case (1'b1)
      (i_opcode == OP_RTYPE): begin
        w_ctrl.alu_op    = ALUOP_RTYPE;
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      (i_opcode == OP_LW): begin
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
      end
      (i_opcode == OP_SW): begin
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      (i_opcode == OP_BEQ): begin
        w_ctrl.alu_op = ALUOP_SUB;
        w_ctrl.beq    = 1'b1;
      end
      (i_opcode == OP_BNE): begin
        w_ctrl.alu_op = ALUOP_SUB;
        w_ctrl.bne    = 1'b1;
      end
      (i_opcode == OP_J): begin
        w_ctrl.jump = 1'b1;
      end
      (i_opcode == OP_ADDI): begin
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      (i_opcode == OP_LOGI): begin
        w_ctrl.alu_op    = ALUOP_LOGI;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      (i_opcode == OP_NOP): begin
        w_ctrl = CTRL_NOP;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign o_ctrl    = w_ctrl;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/control_unit.sv
// Main decoder: decode registered once so the word
// lines up with the decode/execute boundary.
module control_unit
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  control_unit_if.slave  bus
);

  ctrl_t w_ctrl;
  logic  w_illegal;
  ctrl_t r_ctrl;
  logic  r_illegal;

  control_decode u_dec (
    .i_opcode  (bus.opcode),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= CTRL_NOP;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl;
      r_illegal <= w_illegal;
    end
  end

  assign bus.alu_op     = r_ctrl.alu_op;
  assign bus.jump       = r_ctrl.jump;
  assign bus.beq        = r_ctrl.beq;
  assign bus.bne        = r_ctrl.bne;
  assign bus.mem_read   = r_ctrl.mem_read;
  assign bus.mem_write  = r_ctrl.mem_write;
  assign bus.alu_src    = r_ctrl.alu_src;
  assign bus.reg_dst    = r_ctrl.reg_dst;
  assign bus.mem_to_reg = r_ctrl.mem_to_reg;
  assign bus.reg_write  = r_ctrl.reg_write;
  assign bus.illegal_op = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Randomized + directed bench for control_unit
// against a table-driven reference decoder.
module tb_control_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word = {alu_op,jump,beq,bne,mrd,mwr,asrc,rdst,m2r,rwr,ill}
  function automatic logic [11:0] model(input logic [3:0] op);
    logic [1:0] a;
    logic j, bq, bn, mr, mw, as, rd, mr2, rw, il;
    a = 2'b00;
    {j, bq, bn, mr, mw, as, rd, mr2, rw, il} = '0;
    case (op)
      4'h0: begin a = 2'b10; rd = 1; rw = 1; end
      4'h1: begin as = 1; mr = 1; mr2 = 1; rw = 1; end
      4'h2: begin as = 1; mw = 1; end
      4'h3: begin a = 2'b01; bq = 1; end
      4'h4: begin a = 2'b01; bn = 1; end
      4'h5: j = 1;
      4'h6: begin as = 1; rw = 1; end
      4'h7: begin a = 2'b11; as = 1; rw = 1; end
      4'hF: ;
      default: il = 1;
    endcase
    return {a, j, bq, bn, mr, mw, as, rd, mr2, rw, il};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] observe();
    return {bus.alu_op, bus.jump, bus.beq, bus.bne,
            bus.mem_read, bus.mem_write, bus.alu_src,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write,
            bus.illegal_op};
  endfunction

  task automatic step(input logic [3:0] op,
                      input logic r,
                      input string tag);
    logic [11:0] got;
    logic [11:0] exp;
    @(negedge clk);
    bus.opcode = op;
    rst = r;
    @(posedge clk);
    #1;
    got = observe();
    exp = r ? 12'h000 : model(op);
    chk(tag, {20'd0, got}, {20'd0, exp});
    chk("inv_onehot_br",
        32'(bus.jump) + 32'(bus.beq) + 32'(bus.bne) <= 1, 1);
    chk("inv_rd_wr", 32'(bus.mem_read & bus.mem_write), 0);
    chk("inv_sw_nowb", 32'(bus.mem_write & bus.reg_write), 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.opcode = 4'h1;

    step(4'h1, 1'b1, "rst_lw_0");
    step(4'h1, 1'b1, "rst_lw_1");
    step(4'h1, 1'b0, "rel_lw");
    chk("rel_lw_memrd", 32'(bus.mem_read), 1);

    for (int i = 0; i <= 16; i++)
      step(i[3:0], 1'b0, "sweep");
    chk("wrap_rtype_aluop", 32'(bus.alu_op), 2);

    step(4'h3, 1'b0, "beq");
    chk("beq_flag", 32'(bus.beq), 1);
    step(4'h4, 1'b0, "bne");
    chk("bne_flag", 32'(bus.bne), 1);
    step(4'h5, 1'b0, "jump");
    chk("jump_rw", 32'(bus.reg_write), 0);
    step(4'h9, 1'b0, "illegal9");
    chk("ill9_flag", 32'(bus.illegal_op), 1);
    step(4'hF, 1'b0, "nopF");
    chk("nopF_flag", 32'(bus.illegal_op), 0);
    step(4'h2, 1'b0, "sw");
    chk("sw_memwr", 32'(bus.mem_write), 1);
    step(4'h1, 1'b0, "lw_after_sw");
    chk("lw_memwr", 32'(bus.mem_write), 0);

    for (int i = 0; i < 12; i++)
      step(i[0] ? 4'h6 : 4'h0, (i == 5 || i == 6),
           "alt_rst");

    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(15)),
           ($urandom_range(15) == 0), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
